regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised register bank: the next generation of the CPU's two-read/one-write register file.
- Adds a configurable number of read ports, a hardwired-zero option, write-to-read bypass, and a per-register busy scoreboard.
- The scoreboard flags destinations of in-flight multi-cycle results (e.g. LW in the multi-cycle/pipelined datapath), so the controller can stall.
- Sits between decode (read addresses, reservation) and write-back (write port); replaces the file-initialised bank with reset-initialised state.

Parameters:
DATA_W, 32, register data width in bits.
ADDR_W, 5, register address width; depth = 2**ADDR_W.
N_READ, 2, number of read ports (1..4).
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and reservations.
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  asynchronous active-low reset.
ra  input  N_READ*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
rd  output  N_READ*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W].
rd_busy  output  N_READ  port i's register has a pending reservation.
we  input  1  write enable.
wa  input  ADDR_W  write address.
wd  input  DATA_W  write data.
rsv_en  input  1  reserve (mark busy) register rsv_addr.
rsv_addr  input  ADDR_W  register to reserve.
busy_vec  output  2**ADDR_W  full scoreboard, bit n = register n busy.
dbg_addr  input  ADDR_W  debug read address (bench observation, no bypass).
dbg_data  output  DATA_W  contents of register dbg_addr.

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n low immediately clears all registers and all busy bits, independent of clk.
- Because of that clear, rd, rd_busy, busy_vec and dbg_data all read 0 while rst_n is low.
- Deassertion of rst_n is synchronised externally; the first update occurs at the first rising clk edge with rst_n high.
- Write: at the rising edge with we=1 and write allowed, mem[wa] <= wd and busy[wa] <= 0.
  - Write is allowed unless ZERO_REG=1 and wa=0.
  - Write latency: 1 cycle to the storage array; 0 cycles to the read ports when BYPASS=1.
- Reserve: at the rising edge with rsv_en=1, busy[rsv_addr] <= 1. Ignored when ZERO_REG=1 and rsv_addr=0.
- Simultaneous write and reserve, same register: data is written and the busy bit ends at 1 (the new reservation wins).
- Simultaneous write and reserve, different registers: both take effect.
- Read port i (combinational, all ports independent and identical):
  - ZERO_REG=1 and ra_i=0: rd_i=0, rd_busy_i=0.
  - Else if BYPASS=1, we=1, write allowed and wa=ra_i: rd_i=wd, rd_busy_i=0 (the write is completing the pending result).
  - Else: rd_i=mem[ra_i], rd_busy_i=busy[ra_i].
- Multiple ports addressing the same register return identical values.
- BYPASS=0: reads return pre-edge contents; new data is visible the cycle after the write.
- Unreserved write: a write to a register whose busy bit is 0 is legal and leaves it at 0.
- Redundant reservation: reserving an already-busy register is legal and leaves it at 1 (no count, single bit).
- busy_vec: registered state only, no bypass term. Bit 0 is constant 0 when ZERO_REG=1.
- Reset mid-operation: a reset asserted in the same cycle as a write or reserve takes priority; the state stays cleared.
- No X propagation: every register, including register 0 when ZERO_REG=0, is defined after reset.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing r5=0xDEADBEEF -> rd for ra=5 reads 0 immediately (before the next edge); busy_vec=0.
- Write/read with BYPASS=1: we=1, wa=3, wd=0x00000011, ra0=3 in the same cycle -> rd0=0x11 combinationally. Next cycle with we=0 -> rd0=0x11.
- Zero register with ZERO_REG=1: write wa=0, wd=0xFFFFFFFF and rsv_addr=0 -> rd for ra=0 is 0, busy_vec[0]=0. With ZERO_REG=0, the same write reads back 0xFFFFFFFF.
- Scoreboard: rsv_en on r8 -> busy_vec[8]=1 and rd_busy=1 on a port reading r8. A write r8=0x2A two cycles later -> rd_busy=0 and rd=0x2A in the write cycle (bypass), busy_vec[8]=0 after the edge.
- Simultaneous events: we=1, wa=9, wd=7 with rsv_en=1, rsv_addr=9 -> after the edge mem[9]=7 and busy_vec[9]=1. Separately, write r10 and reserve r11 in the same cycle -> r10 updated, only bit 11 set.
- N_READ=4, BYPASS=0: ports read r1, r2, r1, r31 (preloaded 1, 2, 1, 0x1F) -> rd={0x1F,1,2,1}. A write r2=5 in that cycle -> port 1 still shows 2 until the next cycle.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read/write/reserve/debug bus of the register bank
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_READ = 2
);
  logic [N_READ*ADDR_W-1:0] ra;
  logic [N_READ*DATA_W-1:0] rd;
  logic [N_READ-1:0]        rd_busy;
  logic                     we;
  logic [ADDR_W-1:0]        wa;
  logic [DATA_W-1:0]        wd;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [(1<<ADDR_W)-1:0]   busy_vec;
  logic [ADDR_W-1:0]        dbg_addr;
  logic [DATA_W-1:0]        dbg_data;
  modport master (output ra, we, wa, wd, rsv_en, rsv_addr, dbg_addr,
                  input rd, rd_busy, busy_vec, dbg_data);
  modport slave  (input ra, we, wa, wd, rsv_en, rsv_addr, dbg_addr,
                  output rd, rd_busy, busy_vec, dbg_data);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register bank with N read ports, write bypass and per-register busy scoreboard
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic clk,
  input logic rst_n,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic [N_READ*DATA_W-1:0] rd;
  logic [N_READ-1:0]        rd_busy;
  logic                     wr_ok, rsv_ok;
  // rst_n gates the bypass so read ports show the cleared bank during reset
  assign wr_ok  = rst_n && bus.we && !(ZERO_REG != 0 && bus.wa == '0);
  assign rsv_ok = bus.rsv_en && !(ZERO_REG != 0 && bus.rsv_addr == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) begin
        mem[bus.wa]  <= bus.wd;
        busy[bus.wa] <= 1'b0;
      end
      if (rsv_ok) busy[bus.rsv_addr] <= 1'b1;
    end
  for (genvar i = 0; i < N_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              z, h;
    assign a = bus.ra[i*ADDR_W +: ADDR_W];
    assign z = ZERO_REG != 0 && a == '0;
    assign h = BYPASS != 0 && wr_ok && bus.wa == a;
    assign rd[i*DATA_W +: DATA_W] = z ? '0 : h ? bus.wd : mem[a];
    assign rd_busy[i] = !z && !h && busy[a];
  end
  assign bus.rd       = rd;
  assign bus.rd_busy  = rd_busy;
  assign bus.busy_vec = busy;
  assign bus.dbg_data = mem[bus.dbg_addr];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors on a default bank plus a 4-port, no-bypass, no-zero-reg bank
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .N_READ(2)) ia ();
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .N_READ(4)) ib ();

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .N_READ(2), .ZERO_REG(1), .BYPASS(1))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .N_READ(4), .ZERO_REG(0), .BYPASS(0))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rs;
    logic [4:0]  rsa;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [31:0] ebv;
  } vec_t;
  vec_t tv [16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    ia.ra = '0; ia.we = 1'b0; ia.wa = '0; ia.wd = '0; ia.rsv_en = 1'b0; ia.rsv_addr = '0; ia.dbg_addr = '0;
    ib.ra = '0; ib.we = 1'b0; ib.wa = '0; ib.wd = '0; ib.rsv_en = 1'b0; ib.rsv_addr = '0; ib.dbg_addr = '0;
    // state entering each vector: registered values before that vector's edge
    tv[0]  = '{1'b1, 5'd3,  32'h11,       1'b0, 5'd0,  5'd3,  5'd4,  32'h11, 32'h0,  2'b00, 32'h0};
    tv[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'h11, 32'h11, 2'b00, 32'h0};
    tv[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  5'd8,  5'd3,  32'h0,  32'h11, 2'b00, 32'h0};
    tv[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd8,  5'd0,  32'h0,  32'h0,  2'b01, 32'h100};
    tv[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd8,  5'd8,  32'h0,  32'h0,  2'b11, 32'h100};
    tv[5]  = '{1'b1, 5'd8,  32'h2A,       1'b0, 5'd0,  5'd8,  5'd8,  32'h2A, 32'h2A, 2'b00, 32'h100};
    tv[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd8,  5'd3,  32'h2A, 32'h11, 2'b00, 32'h0};
    tv[7]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,  32'h0,  2'b00, 32'h0};
    tv[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd3,  32'h0,  32'h11, 2'b00, 32'h0};
    tv[9]  = '{1'b1, 5'd9,  32'h7,        1'b1, 5'd9,  5'd9,  5'd9,  32'h7,  32'h7,  2'b00, 32'h0};
    tv[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd8,  32'h7,  32'h2A, 2'b01, 32'h200};
    tv[11] = '{1'b1, 5'd10, 32'hA0,       1'b1, 5'd11, 5'd10, 5'd11, 32'hA0, 32'h0,  2'b00, 32'h200};
    tv[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd10, 5'd11, 32'hA0, 32'h0,  2'b10, 32'hA00};
    tv[13] = '{1'b1, 5'd3,  32'h33,       1'b0, 5'd0,  5'd3,  5'd9,  32'h33, 32'h7,  2'b10, 32'hA00};
    tv[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd3,  32'h7,  32'h33, 2'b01, 32'hA00};
    tv[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd8,  32'h7,  32'h2A, 2'b01, 32'hA00};

    ia.ra = {5'd3, 5'd5};
    #1;
    chk("reset_rd_a", 128'(ia.rd), 128'h0);
    chk("reset_busy_a", 128'(ia.busy_vec), 128'h0);
    chk("reset_busy_b", 128'(ib.busy_vec), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ia.we = tv[k].we; ia.wa = tv[k].wa; ia.wd = tv[k].wd;
      ia.rsv_en = tv[k].rs; ia.rsv_addr = tv[k].rsa;
      ia.ra = {tv[k].a1, tv[k].a0};
      #1;
      chk($sformatf("v%0d_rd0", k), 128'(ia.rd[31:0]), 128'(tv[k].e0));
      chk($sformatf("v%0d_rd1", k), 128'(ia.rd[63:32]), 128'(tv[k].e1));
      chk($sformatf("v%0d_rd_busy", k), 128'(ia.rd_busy), 128'(tv[k].eb));
      chk($sformatf("v%0d_busy_vec", k), 128'(ia.busy_vec), 128'(tv[k].ebv));
    end
    @(negedge clk);
    ia.we = 1'b0; ia.rsv_en = 1'b0; ia.dbg_addr = 5'd0;
    #1;
    chk("zero_dbg_r0", 128'(ia.dbg_data), 128'h0);

    // 4-port bank without bypass and with a writable register 0
    ib.we = 1'b1; ib.wa = 5'd1; ib.wd = 32'd1;
    @(negedge clk); ib.wa = 5'd2; ib.wd = 32'd2;
    @(negedge clk); ib.wa = 5'd31; ib.wd = 32'h1F;
    @(negedge clk); ib.wa = 5'd0; ib.wd = 32'hFFFFFFFF; ib.rsv_en = 1'b1; ib.rsv_addr = 5'd0;
    @(negedge clk);
    ib.we = 1'b0; ib.rsv_en = 1'b0; ib.ra = {5'd31, 5'd1, 5'd2, 5'd1}; ib.dbg_addr = 5'd0;
    #1;
    chk("b_dbg_r0", 128'(ib.dbg_data), 128'hFFFFFFFF);
    chk("b_busy_r0", 128'(ib.busy_vec), 128'h1);
    chk("b_rd4", 128'(ib.rd), {32'h1F, 32'd1, 32'd2, 32'd1});
    ib.we = 1'b1; ib.wa = 5'd2; ib.wd = 32'd5;
    #1;
    chk("b_no_bypass", 128'(ib.rd), {32'h1F, 32'd1, 32'd2, 32'd1});
    @(negedge clk);
    ib.we = 1'b0; ib.dbg_addr = 5'd2;
    #1;
    chk("b_rd4_after", 128'(ib.rd), {32'h1F, 32'd1, 32'd5, 32'd1});
    chk("b_dbg_r2", 128'(ib.dbg_data), 128'd5);
    ib.ra = {5'd31, 5'd1, 5'd2, 5'd0};
    #1;
    chk("b_rd_r0", 128'(ib.rd[31:0]), 128'hFFFFFFFF);

    // asynchronous reset mid-cycle, racing a write and a reservation
    @(negedge clk);
    ia.we = 1'b1; ia.wa = 5'd5; ia.wd = 32'hDEADBEEF;
    @(negedge clk);
    ia.we = 1'b0; ia.ra = {5'd6, 5'd5}; ia.dbg_addr = 5'd5;
    #1;
    chk("pre_reset_r5", 128'(ia.rd[31:0]), 128'hDEADBEEF);
    chk("pre_reset_busy", 128'(ia.busy_vec), 128'hA00);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    ia.we = 1'b1; ia.wa = 5'd6; ia.wd = 32'h1234; ia.rsv_en = 1'b1; ia.rsv_addr = 5'd6;
    #1;
    chk("async_rd_r5", 128'(ia.rd[31:0]), 128'h0);
    chk("async_rd_bypass", 128'(ia.rd[63:32]), 128'h0);
    chk("async_busy", 128'(ia.busy_vec), 128'h0);
    chk("async_dbg", 128'(ia.dbg_data), 128'h0);
    chk("async_busy_b", 128'(ib.busy_vec), 128'h0);
    @(posedge clk);
    #1;
    chk("held_busy", 128'(ia.busy_vec), 128'h0);
    @(negedge clk);
    ia.we = 1'b0; ia.rsv_en = 1'b0; ia.dbg_addr = 5'd6;
    rst_n = 1'b1;
    #1;
    chk("post_reset_r6", 128'(ia.dbg_data), 128'h0);
    chk("post_reset_rd_busy", 128'(ia.rd_busy), 128'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
